// File: rtl/onehot_scan_pkg.sv
// onehot_scan_pkg: shared FSM state encoding and mode constants for the one-hot scan decoder
package onehot_scan_pkg;
  typedef enum logic [1:0] {
    OFF    = 2'd0,
    DIRECT = 2'd1,
    SCAN   = 2'd2
  } state_t;
  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;
endpackage

// File: rtl/onehot_dwell_counter.sv
// onehot_dwell_counter: dwell counter (clk, rst, clr, inc, dwell in; expire out when count >= dwell while counting)
module onehot_dwell_counter #(
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               inc,
  input  logic [DWELL_W-1:0] dwell,
  output logic               expire
);
  logic [DWELL_W-1:0] cnt;
  // >= so that lowering dwell below the current count still advances on the next cycle
  assign expire = inc && (cnt >= dwell);
  always_ff @(posedge clk) begin
    if (rst || clr || expire) cnt <= '0;
    else if (inc) cnt <= cnt + 1'b1;
  end
endmodule

// File: rtl/onehot_scan_decoder.sv
// onehot_scan_decoder: registered binary-to-one-hot decoder with direct and auto-scan modes.
// Ports: clk, rst (sync, active-high), en (0 blanks d), mode (0 direct, 1 scan),
//   sel_valid/sel/sel_ready index handshake, dwell (scan hold = dwell+1 cycles),
//   d (registered one-hot), d_idx (registered hot index), wrap (pulse on scan wrap to 0).
// Macro ONEHOT_SCAN_ACTIVE_LOW_EN drives d one-cold (all ones when blank).
module onehot_scan_decoder
  import onehot_scan_pkg::*;
#(
  parameter int SEL_W   = 3,
  parameter int DWELL_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  en,
  input  logic                  mode,
  input  logic                  sel_valid,
  input  logic [SEL_W-1:0]      sel,
  output logic                  sel_ready,
  input  logic [DWELL_W-1:0]    dwell,
  output logic [2**SEL_W-1:0]   d,
  output logic [SEL_W-1:0]      d_idx,
  output logic                  wrap
);
  localparam int OUT_W = 2**SEL_W;
`ifdef ONEHOT_SCAN_ACTIVE_LOW_EN
  localparam logic [OUT_W-1:0] POL = '1;
`else
  localparam logic [OUT_W-1:0] POL = '0;
`endif
  state_t state, nxt;
  logic accept, scanning, expire, adv, wrap_nxt;
  logic [SEL_W-1:0] idx_nxt;
  logic [OUT_W-1:0] hot;
  assign sel_ready = en && !rst;
  assign accept    = sel_valid && sel_ready;
  // counting only continues across an edge that stays in SCAN; any entry or accept restarts it
  assign scanning  = (state == SCAN) && (nxt == SCAN);
  assign adv       = expire && !accept;
  onehot_dwell_counter #(.DWELL_W(DWELL_W)) u_cnt (
    .clk    (clk),
    .rst    (rst),
    .clr    (accept || !scanning),
    .inc    (scanning),
    .dwell  (dwell),
    .expire (expire)
  );
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= OFF;
      d     <= POL;
      d_idx <= '0;
      wrap  <= 1'b0;
    end else begin
      state <= nxt;
      d     <= hot ^ POL;
      d_idx <= idx_nxt;
      wrap  <= wrap_nxt;
    end
  end
  always_comb begin
    nxt = !en ? OFF : (mode == MODE_SCAN ? SCAN : DIRECT);
  end
  always_comb begin
    idx_nxt  = accept ? sel : (adv ? d_idx + 1'b1 : d_idx);
    wrap_nxt = adv && (&d_idx);
    hot      = '0;
    if (nxt != OFF) hot[idx_nxt] = 1'b1;
  end
endmodule

// File: tb/tb_onehot_scan_decoder.sv
// tb_onehot_scan_decoder: directed self-checking bench for onehot_scan_decoder (8-bit and 16-bit instances)
module tb_onehot_scan_decoder;
`ifdef ONEHOT_SCAN_ACTIVE_LOW_EN
  localparam bit INV = 1'b1;
`else
  localparam bit INV = 1'b0;
`endif
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst, en, mode, sel_valid, sel_ready, wrap;
  logic [2:0] sel, d_idx;
  logic [7:0] dwell, d;
  logic rst4, en4, mode4, sv4, rdy4, wrap4;
  logic [3:0] sel4, idx4;
  logic [7:0] dwell4;
  logic [15:0] d4;
  int checks = 0;
  int failures = 0;
  onehot_scan_decoder dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .sel_valid(sel_valid), .sel(sel),
    .sel_ready(sel_ready), .dwell(dwell), .d(d), .d_idx(d_idx), .wrap(wrap)
  );
  onehot_scan_decoder #(.SEL_W(4), .DWELL_W(8)) dut4 (
    .clk(clk), .rst(rst4), .en(en4), .mode(mode4), .sel_valid(sv4), .sel(sel4),
    .sel_ready(rdy4), .dwell(dwell4), .d(d4), .d_idx(idx4), .wrap(wrap4)
  );
  function automatic logic [7:0] e8(input logic [7:0] v);
    return INV ? ~v : v;
  endfunction
  function automatic logic [15:0] e16(input logic [15:0] v);
    return INV ? ~v : v;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_pos(input string tag, input logic [2:0] idx, input logic w);
    chk({tag, "_d"}, 32'(d), 32'(e8(8'b1 << idx)));
    chk({tag, "_idx"}, 32'(d_idx), 32'(idx));
    chk({tag, "_wrap"}, 32'(wrap), 32'(w));
  endtask
  initial begin
    rst = 1; en = 1; mode = 0; sel_valid = 0; sel = 0; dwell = 0;
    rst4 = 1; en4 = 1; mode4 = 0; sv4 = 0; sel4 = 0; dwell4 = 0;
    tick();
    chk("rst_d", 32'(d), 32'(e8(8'h00)));
    chk("rst_idx", 32'(d_idx), 0);
    chk("rst_wrap", 32'(wrap), 0);
    chk("rst_ready", 32'(sel_ready), 0);
    // direct decode
    rst = 0; sel_valid = 1; sel = 3'd5;
    #1 chk("ready_en", 32'(sel_ready), 1);
    tick();
    chk_pos("direct5", 3'd5, 1'b0);
    sel_valid = 0; sel = 3'd2;
    tick();
    chk_pos("direct_hold", 3'd5, 1'b0);
    rst = 1;
    tick();
    chk("rst2_d", 32'(d), 32'(e8(8'h00)));
    chk("rst2_idx", 32'(d_idx), 0);
    // scan with dwell=2 through a full wrap
    rst = 0; mode = 1; dwell = 8'd2;
    tick();
    chk_pos("scan_entry", 3'd0, 1'b0);
    for (int p = 1; p <= 8; p++) begin
      tick(); tick();
      chk_pos("scan_dwell", 3'(p - 1), 1'b0);
      tick();
      chk_pos("scan_step", 3'(p), p == 8);
    end
    tick();
    chk_pos("scan_after_wrap", 3'd0, 1'b0);
    // live dwell change to 0: count already exceeds it
    dwell = 8'd0;
    tick();
    chk_pos("dwell0_a", 3'd1, 1'b0);
    tick();
    chk_pos("dwell0_b", 3'd2, 1'b0);
    repeat (5) tick();
    chk_pos("dwell0_at7", 3'd7, 1'b0);
    // accept collides with expiry at index 7
    dwell = 8'd2;
    tick(); tick();
    chk_pos("pre_collide", 3'd7, 1'b0);
    sel_valid = 1; sel = 3'd3;
    tick();
    chk_pos("collide", 3'd3, 1'b0);
    sel_valid = 0;
    tick(); tick();
    chk_pos("collide_restart", 3'd3, 1'b0);
    tick();
    chk_pos("collide_adv", 3'd4, 1'b0);
    // enable blanking at index 4
    en = 0;
    #1 chk("blank_ready", 32'(sel_ready), 0);
    sel_valid = 1; sel = 3'd1;
    tick();
    chk("blank_d", 32'(d), 32'(e8(8'h00)));
    chk("blank_idx", 32'(d_idx), 4);
    chk("blank_wrap", 32'(wrap), 0);
    sel_valid = 0;
    tick();
    chk("blank_hold_idx", 32'(d_idx), 4);
    en = 1;
    tick();
    chk_pos("reenable", 3'd4, 1'b0);
    tick(); tick();
    chk_pos("reenable_full", 3'd4, 1'b0);
    tick();
    chk_pos("reenable_adv", 3'd5, 1'b0);
    repeat (3) tick();
    chk_pos("at6", 3'd6, 1'b0);
    // SCAN -> DIRECT holds position
    mode = 0;
    tick();
    chk_pos("to_direct", 3'd6, 1'b0);
    repeat (4) tick();
    chk_pos("direct_hold6", 3'd6, 1'b0);
    mode = 1;
    tick(); tick(); tick();
    chk_pos("to_scan_held", 3'd6, 1'b0);
    rst = 1;
    tick();
    chk("midrst_d", 32'(d), 32'(e8(8'h00)));
    chk("midrst_idx", 32'(d_idx), 0);
    chk("midrst_wrap", 32'(wrap), 0);
    rst = 0;
    // 16-output instance
    chk("w16_rst_d", 32'(d4), 32'(e16(16'h0000)));
    rst4 = 0; sv4 = 1; sel4 = 4'd9;
    tick();
    chk("w16_sel9_d", 32'(d4), 32'(e16(16'h0200)));
    chk("w16_sel9_idx", 32'(idx4), 9);
    sel4 = 4'd15;
    tick();
    chk("w16_sel15_d", 32'(d4), 32'(e16(16'h8000)));
    sv4 = 0; mode4 = 1;
    tick();
    chk("w16_entry_idx", 32'(idx4), 15);
    tick();
    chk("w16_wrap_d", 32'(d4), 32'(e16(16'h0001)));
    chk("w16_wrap_idx", 32'(idx4), 0);
    chk("w16_wrap", 32'(wrap4), 1);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/onehot_scan_decoder.md
Name: onehot_scan_decoder

Overview:
Registered, parametrised binary-to-one-hot decoder, generalising the 3-to-8 combinational decoder to SEL_W inputs and 2^SEL_W outputs.
- Two modes: direct (decode an accepted index) and scan (auto-rotate the hot bit with a programmable dwell).
- Drives digit or row selects for multiplexed displays and LED matrices in the lab designs.
- Index acceptance uses a valid/ready handshake.

Parameters:
SEL_W, 3, index width; output width OUT_W = 2**SEL_W (derived localparam, not overridable)
DWELL_W, 8, width of dwell count (cycles per scan position minus one)

Ports:
clk  in  1  rising-edge clock, single clock domain
rst  in  1  synchronous reset, active-high
en  in  1  block enable; 0 blanks output
mode  in  1  0 = direct, 1 = scan
sel_valid  in  1  sel presents a new index
sel  in  SEL_W  requested index
sel_ready  out  1  index accepted this cycle when sel_valid && sel_ready
dwell  in  DWELL_W  scan dwell; position held for dwell+1 cycles
d  out  OUT_W  registered one-hot output
d_idx  out  SEL_W  registered index of the hot bit
wrap  out  1  one-cycle pulse when scan wraps from OUT_W-1 to 0

Behaviour:
- All outputs are registered; nothing is combinational from input to output except sel_ready.
- Reset (rst=1 at clk edge):
  - d=0, d_idx=0, wrap=0, dwell counter=0.
  - State goes to OFF; rst overrides every other input.
- sel_ready = en && !rst (combinational); no sel is accepted while en=0.
- FSM states, evaluated every edge:
  - OFF: d=0 and d_idx holds its value.
  - DIRECT
  - SCAN
- FSM transitions:
  - Next state is OFF if en=0, else DIRECT if mode=0, else SCAN.
  - OFF->DIRECT/SCAN: d = 1<<d_idx on the first enabled edge; dwell counter is cleared.
- DIRECT mode:
  - On accept, d = 1<<sel and d_idx = sel at the next edge (latency 1).
  - Without an accept, d and d_idx hold.
- SCAN mode:
  - The dwell counter increments each cycle. When counter == dwell, the counter clears and d_idx advances by 1 (modulo OUT_W); d follows d_idx.
  - dwell=0 advances every cycle.
  - dwell is sampled live, so a change takes effect immediately. If counter > new dwell, the comparison uses >= so the position advances on the next cycle.
  - Wrap: advance from OUT_W-1 to 0 asserts wrap in the same cycle d_idx becomes 0. wrap is 0 otherwise, in DIRECT and in OFF.
  - An accept in SCAN jumps to d_idx = sel, clears the counter and suppresses advance and wrap that cycle. The accept has priority over dwell expiry.
- Mode switches:
  - SCAN->DIRECT holds the current d_idx and d.
  - DIRECT->SCAN starts from the current d_idx with the counter cleared.
- Invariant: d is exactly one-hot or all-zero at every cycle; d_idx is always consistent with d when d != 0.

Optional Feature:
- Macro: ONEHOT_SCAN_ACTIVE_LOW_EN.
- Defined: d is driven inverted (one-cold) for common-anode displays.
  - Reset and OFF value is all ones.
  - The active position is a single 0.
  - d_idx and wrap are unchanged.
- Undefined: active-high one-hot as specified above.

Decomposition:
- Shared package onehot_scan_pkg holds:
  - The state encoding (OFF=2'd0, DIRECT=2'd1, SCAN=2'd2).
  - Mode constants MODE_DIRECT=1'b0, MODE_SCAN=1'b1.
- One natural sub-module: onehot_dwell_counter (DWELL_W counter with clear, dwell compare and expire pulse), instantiated once.
- Decode (1<<idx) and output inversion remain in the top level.

Test Plan:
1. Reset and direct decode: rst=1 with en=1, then release; mode=0, sel_valid=1, sel=3'd5 -> one cycle later d=8'b00100000, d_idx=5; after rst, d=0.
2. Scan with wrap: en=1, mode=1, dwell=2, start idx=0 -> d_idx steps 0,1,...,7,0 every 3 cycles; wrap is high for exactly one cycle coinciding with d_idx=0; dwell=0 gives a new position every cycle.
3. Accept collides with expiry: in SCAN at d_idx=7 on the cycle the counter reaches dwell, sel_valid=1, sel=3 -> d_idx=3, wrap=0, counter restarts at 0.
4. Enable blanking: en=0 mid-scan at d_idx=4 -> d=0 next cycle, sel_ready=0, d_idx holds 4; re-enable -> d=8'b00010000 and dwell restarts full.
5. Mode switch plus mid-operation reset: SCAN->DIRECT at d_idx=6 -> d holds 8'b01000000; rst asserted during SCAN -> d=0, d_idx=0, wrap=0 next edge.
6. Parameter sweep and active-low macro: SEL_W=4 with ONEHOT_SCAN_ACTIVE_LOW_EN defined -> 16-bit one-cold outputs, reset d=16'hFFFF, sel=4'd9 gives d=16'hFDFF.
